// File: rtl/ntt_seq_pkg.sv
// Shared encodings, sizes and FSM state type for the NTT butterfly sequencer.
// NTT_SEQ_BYPASS_EN additionally makes mode 10 (bypass) a legal start mode.
package ntt_seq_pkg;

  localparam int N      = 256;
  localparam int LAYERS = 7;

  typedef enum logic [1:0] {
    MODE_NTT    = 2'b00,
    MODE_INTT   = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_IDLE   = 2'b11
  } bf_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  function automatic logic mode_legal(input logic [1:0] m);
`ifdef NTT_SEQ_BYPASS_EN
    return (m != MODE_IDLE);
`else
    return (m == MODE_NTT) || (m == MODE_INTT);
`endif
  endfunction

endpackage

// File: rtl/ntt_bf_sequencer_ntt_wb_delay.sv
// LAT-deep shift register carrying {valid, addr_a, addr_b} from issue to write-back.
// Reset clears every stage so an aborted transform produces no late writes.
module ntt_wb_delay #(
  parameter int LAT = 7,
  parameter int AW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_vld,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b
);

  logic [LAT-1:0] vld_sr;
  logic [AW-1:0]  a_sr [LAT];
  logic [AW-1:0]  b_sr [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int s = 0; s < LAT; s++) begin
        a_sr[s] <= '0;
        b_sr[s] <= '0;
      end
    end else begin
      vld_sr  <= {vld_sr[LAT-2:0], in_vld};
      a_sr[0] <= in_addr_a;
      b_sr[0] <= in_addr_b;
      for (int s = 1; s < LAT; s++) begin
        a_sr[s] <= a_sr[s-1];
        b_sr[s] <= b_sr[s-1];
      end
    end
  end

  assign out_vld    = vld_sr[LAT-1];
  assign out_addr_a = a_sr[LAT-1];
  assign out_addr_b = b_sr[LAT-1];

endmodule

// File: rtl/ntt_bf_sequencer.sv
// Address/twiddle sequencer for a 256-point in-place NTT/INTT, one butterfly pair per cycle.
// Optional bypass mode (pairs 2i/2i+1, single layer) is compiled in with NTT_SEQ_BYPASS_EN.
module ntt_bf_sequencer
  import ntt_seq_pkg::*;
#(
  parameter int LAT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode_i,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_idx,
  output logic [1:0] bf_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  state_t     state;
  logic [1:0] mode_q;
  logic [6:0] i_cnt;
  logic [2:0] layer;
  logic [2:0] sh;          // log2 of the layer half-span
  logic [6:0] k;
  logic [3:0] drain_cnt;

  logic [7:0] i_ext;
  logic [7:0] len_mask;
  logic [3:0] sh_p1;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic       group_end;
  logic       bypass_q;
  logic       last_layer;

`ifdef NTT_SEQ_BYPASS_EN
  assign bypass_q = (mode_q == MODE_BYPASS);
`else
  assign bypass_q = 1'b0;
`endif

  // Inserting a zero bit at position sh gives (i/len)*2*len + (i mod len).
  assign i_ext      = {1'b0, i_cnt};
  assign len_mask   = (8'd1 << sh) - 8'd1;
  assign sh_p1      = {1'b0, sh} + 4'd1;
  assign addr_a     = ((i_ext >> sh) << sh_p1) | (i_ext & len_mask);
  assign addr_b     = addr_a | (8'd1 << sh);
  assign group_end  = ((i_ext & len_mask) == len_mask);
  assign last_layer = bypass_q || (layer == 3'(LAYERS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= MODE_IDLE;
      i_cnt     <= '0;
      layer     <= '0;
      sh        <= '0;
      k         <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      bf_mode   <= MODE_IDLE;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          busy    <= 1'b0;
          bf_mode <= MODE_IDLE;
          if (start && mode_legal(mode_i)) begin
            state     <= S_ISSUE;
            busy      <= 1'b1;
            bf_mode   <= mode_i;
            mode_q    <= mode_i;
            i_cnt     <= '0;
            layer     <= '0;
            drain_cnt <= '0;
            if (mode_i == MODE_INTT) begin
              sh <= 3'd1;
              k  <= 7'd127;
            end
`ifdef NTT_SEQ_BYPASS_EN
            else if (mode_i == MODE_BYPASS) begin
              sh <= 3'd0;
              k  <= 7'd0;
            end
`endif
            else begin
              sh <= 3'd7;
              k  <= 7'd1;
            end
          end
        end
        S_ISSUE: begin
          rd_en     <= 1'b1;
          rd_addr_a <= addr_a;
          rd_addr_b <= addr_b;
          tw_idx    <= k;
          // k runs on across layer boundaries; only a group end moves it.
          if (group_end && !bypass_q)
            k <= (mode_q == MODE_INTT) ? k - 7'd1 : k + 7'd1;
          i_cnt <= i_cnt + 7'd1;
          if (i_cnt == 7'd127) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 4'd1;
          if (drain_cnt == 4'(LAT - 1)) begin
            if (last_layer) begin
              state <= S_FINISH;
            end else begin
              state <= S_ISSUE;
              layer <= layer + 3'd1;
              sh    <= (mode_q == MODE_INTT) ? sh + 3'd1 : sh - 3'd1;
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ntt_wb_delay #(
    .LAT (LAT),
    .AW  (8)
  ) u_wb_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (rd_en),
    .in_addr_a  (rd_addr_a),
    .in_addr_b  (rd_addr_b),
    .out_vld    (wr_en),
    .out_addr_a (wr_addr_a),
    .out_addr_b (wr_addr_b)
  );

endmodule

// File: tb/tb_ntt_bf_sequencer.sv
// Directed bench: a reference model queues every expected issue; a monitor checks reads, write-backs and done.
module tb_ntt_bf_sequencer;

  localparam int LAT = 7;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] tw;
    logic [2:0] layer;
    logic [6:0] i;
  } iss_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_idx;
  logic [1:0] bf_mode;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   low_run = 0;
  logic [1:0] exp_mode = 2'b11;
  iss_t exp_rd[$];
  iss_t wr_q[$];

  ntt_bf_sequencer #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode_i    (mode_i),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .bf_mode   (bf_mode),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: explicit division/modulo form of the pair addresses.
  task automatic push_expected(input logic [1:0] m);
    int   len;
    int   k;
    iss_t e;
    if (m == 2'b10) begin
      for (int i = 0; i < 128; i++) begin
        e.a = 8'(2 * i); e.b = 8'(2 * i + 1); e.tw = 7'd0; e.layer = 3'd0; e.i = 7'(i);
        exp_rd.push_back(e);
      end
    end else begin
      k   = (m == 2'b00) ? 1 : 127;
      len = (m == 2'b00) ? 128 : 2;
      for (int l = 0; l < 7; l++) begin
        for (int i = 0; i < 128; i++) begin
          e.a = 8'((i / len) * 2 * len + (i % len));
          e.b = 8'((i / len) * 2 * len + (i % len) + len);
          e.tw = 7'(k); e.layer = 3'(l); e.i = 7'(i);
          exp_rd.push_back(e);
          if (i % len == len - 1) k = (m == 2'b00) ? k + 1 : k - 1;
        end
        len = (m == 2'b00) ? len / 2 : len * 2;
      end
    end
  endtask

  always @(negedge clk) begin
    iss_t e;
    iss_t w;
    if (rst_n) begin
      if (wr_en) begin
        n_tests++;
        assert (wr_q.size() != 0) else begin
          n_fail++;
          $error("FAIL wr_unexpected observed=%0h/%0h expected=none", wr_addr_a, wr_addr_b);
        end
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("wr_pair", {16'd0, wr_addr_a, wr_addr_b}, {16'd0, w.a, w.b});
        end
        wr_cnt++;
      end
      if (rd_en) begin
        n_tests++;
        assert (exp_rd.size() != 0) else begin
          n_fail++;
          $error("FAIL rd_unexpected observed=%0h/%0h expected=none", rd_addr_a, rd_addr_b);
        end
        if (exp_rd.size() != 0) begin
          e = exp_rd.pop_front();
          check("rd_issue", {7'd0, rd_addr_a, rd_addr_b, tw_idx, bf_mode},
                            {7'd0, e.a, e.b, e.tw, exp_mode});
          if (e.i == 7'd0 && e.layer != 3'd0) begin
            check("layer_gap", 32'(low_run), 32'(LAT));
            check("layer_overlap", 32'(wr_q.size() == 0 || wr_q[0].layer == e.layer), 32'd1);
          end
          wr_q.push_back(e);
        end
        rd_cnt++;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy_nowr", {30'd0, busy, wr_en}, {30'd0, 1'b1, 1'b0});
      end
    end
  end

  // One full transform; poke_at > 0 pulses an illegal-time INTT start that many cycles in.
  task automatic run(input string tag, input logic [1:0] m, input int exp_len,
                     input int exp_wr, input int poke_at);
    int d0;
    int w0;
    int t0;
    push_expected(m);
    exp_mode = m;
    d0 = done_cnt;
    w0 = wr_cnt;
    mode_i = m;
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    mode_i = 2'b00;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    for (int c = 1; c < 2000 && done_cnt == d0; c++) begin
      start  = (c == poke_at);
      mode_i = (c == poke_at) ? 2'b01 : 2'b00;
      tick();
    end
    start = 1'b0;
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_done_time"}, 32'(done_cyc - t0), 32'(exp_len));
    check({tag, "_wr_count"}, 32'(wr_cnt - w0), 32'(exp_wr));
    check({tag, "_queues_empty"}, 32'(exp_rd.size() + wr_q.size()), 32'd0);
    check({tag, "_idle_after"}, {29'd0, busy, bf_mode}, {29'd0, 1'b0, 2'b11});
    exp_mode = 2'b11;
  endtask

  task automatic ignored_start(input string tag, input logic [1:0] m);
    int r0;
    int d0;
    r0 = rd_cnt;
    d0 = done_cnt;
    mode_i = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode_i = 2'b00;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    repeat (20) tick();
    check({tag, "_no_activity"}, 32'(rd_cnt - r0 + done_cnt - d0), 32'd0);
    check({tag, "_bf_mode"}, 32'(bf_mode), 32'd3);
  endtask

  initial begin
    int r0;
    int w0;
    int d0;
    repeat (3) tick();
    check("rst_ctrl", {27'd0, busy, done, rd_en, wr_en, 1'b0}, 32'd0);
    check("rst_bf_mode", 32'(bf_mode), 32'd3);
    check("rst_rd_addr", {16'd0, rd_addr_a, rd_addr_b}, 32'd0);
    check("rst_wr_addr", {16'd0, wr_addr_a, wr_addr_b}, 32'd0);
    check("rst_tw", 32'(tw_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    run("ntt", 2'b00, 946, 896, 0);
    run("intt", 2'b01, 946, 896, 0);
    run("ntt_poke", 2'b00, 946, 896, 300);
    ignored_start("mode11", 2'b11);

`ifdef NTT_SEQ_BYPASS_EN
    run("bypass", 2'b10, 128 + LAT + 1, 128, 0);
`else
    ignored_start("mode10", 2'b10);
`endif

    // Abort during the third layer's issue phase.
    push_expected(2'b00);
    exp_mode = 2'b00;
    mode_i = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 1000 && rd_cnt < 0; c++) tick();
    r0 = rd_cnt;
    for (int c = 0; c < 1000 && rd_cnt < r0 + 256 + 10; c++) tick();
    check("abort_reached_l3", 32'(rd_cnt >= r0 + 256 + 10), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_state", {27'd0, busy, done, rd_en, wr_en, 1'b0}, 32'd0);
    check("abort_bf_mode", 32'(bf_mode), 32'd3);
    exp_rd.delete();
    wr_q.delete();
    exp_mode = 2'b11;
    rst_n = 1'b1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    d0 = done_cnt;
    repeat (LAT + 30) tick();
    check("abort_quiet", 32'(rd_cnt - r0 + wr_cnt - w0 + done_cnt - d0), 32'd0);

    run("ntt_after_abort", 2'b00, 946, 896, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_bf_sequencer.md
NTT_BF_SEQUENCER -- requirements
Module: ntt_bf_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 7: cycles from an issue (rd_en) to its matching write-back (wr_en), covering the memory read and the butterfly pipeline; legal range 2..15.
REQ-002 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1: single-cycle request to run one transform.
REQ-005 SHALL have port mode_i, input, 2: transform select (00 NTT, 01 INTT, 10 bypass, 11 reserved); sampled only with an accepted start.
REQ-006 SHALL have outputs busy (1, transform in progress) and done (1, single-cycle completion pulse).
REQ-007 SHALL have outputs rd_en (1), rd_addr_a (8) and rd_addr_b (8): coefficient-pair read request.
REQ-008 SHALL have outputs tw_idx (7, twiddle ROM index) and bf_mode (2, butterfly mode for this transform).
REQ-009 SHALL have outputs wr_en (1), wr_addr_a (8) and wr_addr_b (8): result-pair write-back.

Function
REQ-010 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> (ISSUE for the next layer | FINISH) -> IDLE.
REQ-011 SHALL accept start only in IDLE with a legal mode_i; start in any other state SHALL be ignored.
REQ-012 SHALL raise busy in the cycle after an accepted start and hold it high until the cycle done pulses, inclusive.
REQ-013 SHALL issue exactly one pair per ISSUE cycle: 128 issues per layer, 7 layers for NTT/INTT.
REQ-014 SHALL use layer half-span len = 128,64,...,2 for NTT and len = 2,4,...,128 for INTT.
REQ-015 SHALL compute, for issue counter i in 0..127: rd_addr_a = (i/len)*2*len + (i mod len) and rd_addr_b = rd_addr_a + len.
REQ-016 SHALL generate tw_idx from counter k, which changes once per group (every len issues): NTT k starts at 1 and increments; INTT k starts at 127 and decrements; k SHALL run continuously across layers.
REQ-017 SHALL enter DRAIN after the 128th issue of a layer and stay there until no issue is in flight (LAT cycles), preventing read-after-write hazards between layers.
REQ-018 SHALL drive wr_en/wr_addr_a/wr_addr_b exactly LAT cycles after the corresponding rd_en/rd_addr_a/rd_addr_b.
REQ-019 SHALL enter FINISH after the last layer drains and pulse done for one cycle; done SHALL come after the final wr_en, never with it.
REQ-020 SHALL hold bf_mode at the accepted mode while busy and at 11 (idle) otherwise.
REQ-021 SHALL hold rd_en low outside ISSUE; address and tw_idx values are don't-care when rd_en is low.

Reset
REQ-022 SHALL, with rst_n low at a clock edge, go to IDLE, clear all counters and the write-back delay line, and drive busy=0, done=0, rd_en=0, wr_en=0, bf_mode=11, all addresses and tw_idx=0.
REQ-023 SHALL, on reset in the middle of a transform, abort it with no further wr_en and no done.

Configuration
REQ-024 SHALL use macro NTT_SEQ_BYPASS_EN: when defined, mode_i=10 is legal and runs a single layer of 128 issues with a=2i, b=2i+1, tw_idx=0, bf_mode=10, then DRAIN and FINISH.
REQ-025 SHALL, without NTT_SEQ_BYPASS_EN, treat mode_i=10 like 11: start is ignored and no logic for bypass is present.

Structure
REQ-026 SHALL take mode encodings (NTT, INTT, BYPASS, IDLE), N=256, LAYERS=7 and the FSM state type from shared package ntt_seq_pkg.
REQ-027 SHALL implement the LAT-deep shift register carrying {valid, addr_a, addr_b} as sub-module ntt_wb_delay.

Verification
REQ-028 SHALL check NTT with LAT=7, start at edge T0: first issue a=0, b=128, tw=1; layer-2 issue 64 a=128, b=192, tw=3; final issue a=253, b=255, tw=127; done at T0+946.
REQ-029 SHALL check INTT: first issue a=0, b=2, tw=127; last layer's issues all use tw=1 with a=i, b=i+128; 896 total wr_en pulses, each equal to the matching read pair.
REQ-030 SHALL check layer boundaries: rd_en is low for exactly LAT cycles between layers, and no rd_en overlaps a pending wr_en of the previous layer.
REQ-031 SHALL check start pulsed during busy and start with mode_i=11: ignored, counters unchanged, no extra done.
REQ-032 SHALL check rst_n low during layer 3 issue: next cycle busy=0, bf_mode=11, no wr_en or done afterwards; a fresh start then runs to correct completion.
REQ-033 SHALL check, with NTT_SEQ_BYPASS_EN defined, mode 10: pairs (0,1)...(254,255), bf_mode=10, done at T0+128+LAT+1; without the macro, start is ignored.
